operand_serializer: RTL and testbench



---
 rtl/operand_serializer.sv | 87 ++++++++
 tb/tb_operand_serializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_serializer.sv
// Loads an A/B operand pair via valid/ready and emits it LSB-first, one bit pair per shift_en cycle.
// First bit appears the cycle after the load; shift_en=0 stalls in place; the next load is accepted in the DONE cycle.
module operand_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    a_bit      = 1'b0;
    b_bit      = 1'b0;
    bit_valid  = 1'b0;
    first_bit  = 1'b0;
    last_bit   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = !rst;
      end
      SHIFT: begin
        a_bit     = a_sh[0];
        b_bit     = b_sh[0];
        bit_valid = shift_en;
        // framing strobes follow the word position, not the stall
        first_bit = (cnt == '0);
        last_bit  = (cnt == LAST);
        busy      = 1'b1;
        if (shift_en && cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done       = 1'b1;
        load_ready = !rst;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (load_valid && load_ready) state_nxt = SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load_valid && load_ready) begin
        a_sh <= a;
        b_sh <= b;
        cnt  <= '0;
      end else if (state == SHIFT && shift_en) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_serializer.sv
// Bench for operand_serializer (WIDTH=8): vector table, corner sequences, random run against a queue model.
module tb_operand_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       load_valid;
  logic       load_ready;
  logic       shift_en;
  logic       a_bit;
  logic       b_bit;
  logic       bit_valid;
  logic       first_bit;
  logic       last_bit;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  operand_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .load_valid(load_valid), .load_ready(load_ready), .shift_en(shift_en),
    .a_bit(a_bit), .b_bit(b_bit), .bit_valid(bit_valid),
    .first_bit(first_bit), .last_bit(last_bit), .busy(busy), .done(done)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         st;       // first stalled cycle after load, 0 = none
    int         sl;       // stall length
    bit         noise;    // drive load_valid/a=0 while shifting
    int         exp_done; // cycle after the load edge where done is high
  } vec_t;

  vec_t vecs[5];

  function automatic logic [7:0] outs();
    return {load_ready, a_bit, b_bit, bit_valid, first_bit, last_bit, busy, done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load_valid = 1'b0; shift_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    a = va; b = vb; load_valid = 1'b1; shift_en = 1'b1;
    #1;
    chk("load_ready_before_load", load_ready, 1);
  endtask

  // Runs from the cycle after a transfer until done (or a 40-cycle budget).
  task automatic collect(input logic [7:0] ea, input int st, input int sl, input bit noise,
                         output logic [7:0] wa, output logic [7:0] wb,
                         output int done_c, output int first_c, output int errs);
    int idx;
    idx = 0; done_c = -1; first_c = -1; errs = 0; wa = '0; wb = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      shift_en   = !(st > 0 && c >= st && c < st + sl);
      load_valid = noise;
      if (noise) begin a = '0; b = '0; end
      #1;
      if (done) begin
        load_valid = 1'b0;
        done_c = c;
        break;
      end
      if (!busy || load_ready) errs++;
      if (first_bit != (idx == 0) || last_bit != (idx == 7)) errs++;
      if (bit_valid) begin
        if (idx < 8) begin wa[idx] = a_bit; wb[idx] = b_bit; end
        if (first_bit && first_c < 0) first_c = c;
        idx++;
      end else if (idx < 8 && a_bit != ea[idx]) begin
        errs++;
      end
    end
  endtask

  initial begin
    logic [7:0] wa, wb;
    int dc, fc, er;
    bit qa[$];
    bit qb[$];
    int pos;
    bit done_now;
    bit nd;
    logic [7:0] exp_o;

    vecs[0] = '{8'hA5, 8'h3C, 0, 0, 1'b0, 9};
    vecs[1] = '{8'hA5, 8'h3C, 4, 3, 1'b0, 12};
    vecs[2] = '{8'hA5, 8'h3C, 0, 0, 1'b1, 9};
    vecs[3] = '{8'h0F, 8'h00, 0, 0, 1'b0, 9};
    vecs[4] = '{8'hFF, 8'h01, 2, 1, 1'b1, 10};

    rst = 1'b1; a = '0; b = '0; load_valid = 1'b1; shift_en = 1'b0;
    @(negedge clk); #1;
    chk("reset_load_ready", load_ready, 0);
    chk("reset_outputs", outs(), 8'h00);
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b0; #1;
    chk("idle_outputs", outs(), 8'h80);

    foreach (vecs[i]) begin
      do_reset();
      load(vecs[i].a, vecs[i].b);
      collect(vecs[i].a, vecs[i].st, vecs[i].sl, vecs[i].noise, wa, wb, dc, fc, er);
      chk($sformatf("vec%0d_a_word", i), wa, vecs[i].a);
      chk($sformatf("vec%0d_b_word", i), wb, vecs[i].b);
      chk($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
      chk($sformatf("vec%0d_first_cycle", i), fc, 1);
      chk($sformatf("vec%0d_stream_errs", i), er, 0);
      chk($sformatf("vec%0d_done_outputs", i), outs(), 8'h81);
      @(negedge clk); #1;
      chk($sformatf("vec%0d_after_done", i), outs(), 8'h80);
    end

    // back-to-back: second load accepted in the DONE cycle
    do_reset();
    load(8'hFF, 8'h01);
    collect(8'hFF, 0, 0, 1'b0, wa, wb, dc, fc, er);
    chk("b2b_first_done", dc, 9);
    chk("b2b_ready_in_done", load_ready, 1);
    a = 8'h00; b = 8'h80; load_valid = 1'b1;
    collect(8'h00, 0, 0, 1'b0, wa, wb, dc, fc, er);
    chk("b2b_second_first_cycle", fc, 1);
    chk("b2b_second_a", wa, 8'h00);
    chk("b2b_second_b", wb, 8'h80);
    chk("b2b_second_done", dc, 9);
    chk("b2b_second_errs", er, 0);

    // reset after the 4th bit
    do_reset();
    load(8'hA5, 8'h3C);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      load_valid = 1'b0; shift_en = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1; #1;
    chk("midword_rst_ready", load_ready, 0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("midword_rst_idle", outs(), 8'h80);
    load(8'h0F, 8'h00);
    collect(8'h0F, 0, 0, 1'b0, wa, wb, dc, fc, er);
    chk("after_rst_a", wa, 8'h0F);
    chk("after_rst_first", fc, 1);
    chk("after_rst_errs", er, 0);

    // reset during DONE with a pending load
    @(negedge clk);
    load_valid = 1'b0;
    load(8'h3C, 8'hA5);
    collect(8'h3C, 0, 0, 1'b0, wa, wb, dc, fc, er);
    rst = 1'b1; load_valid = 1'b1; #1;
    chk("done_rst_ready", load_ready, 0);
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b0; #1;
    chk("done_rst_idle", outs(), 8'h80);

    // random traffic against a queue-of-bits model
    qa.delete(); qb.delete(); pos = 0; done_now = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst        = (c == 0) || ($urandom_range(0, 39) == 0);
      load_valid = ($urandom_range(0, 2) != 0);
      shift_en   = ($urandom_range(0, 3) != 0);
      a          = 8'($urandom);
      b          = 8'($urandom);
      #1;
      exp_o = '0;
      exp_o[7] = (qa.size() == 0) && !rst;
      if (qa.size() > 0) begin
        exp_o[6] = qa[0];
        exp_o[5] = qb[0];
        exp_o[4] = shift_en;
        exp_o[3] = (pos == 0);
        exp_o[2] = (qa.size() == 1);
        exp_o[1] = 1'b1;
      end else if (done_now) begin
        exp_o[0] = 1'b1;
      end
      chk($sformatf("rand_cycle%0d", c), outs(), exp_o);
      if (rst) begin
        qa.delete(); qb.delete(); pos = 0; done_now = 1'b0;
      end else begin
        nd = 1'b0;
        if (qa.size() > 0 && shift_en) begin
          void'(qa.pop_front());
          void'(qb.pop_front());
          pos++;
          if (qa.size() == 0) nd = 1'b1;
        end
        if (load_valid && exp_o[7]) begin
          for (int i = 0; i < 8; i++) begin
            qa.push_back(a[i]);
            qb.push_back(b[i]);
          end
          pos = 0;
          nd = 1'b0;
        end
        done_now = nd;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
